// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline: default field widths,
// write-back select encoding and the reset value of one slot.
package mem_wb_pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;

   // Encoding of the MemtoReg control as a write-back source select.
   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;

   // One pipeline slot at the default widths.
   typedef struct packed {
      logic                  valid;
      logic [DATA_W_DEF-1:0] alu;
      logic [DATA_W_DEF-1:0] mem;
      logic [REG_W_DEF-1:0]  rd;
      logic                  mem_to_reg;
      logic                  reg_write;
   } slot_t;

   localparam slot_t SLOT_RST = '0;

endpackage

// File: rtl/mem_wb_if.sv
// MEM->WB bus: MEM-stage inputs, stall/flush, forwarding lookup and
// write-back outputs. The master is the pipeline control side.
interface mem_wb_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 32
);
   logic              in_valid;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] mem_read_data;
   logic [REG_W-1:0]  write_reg_num;
   logic              mem_to_reg;
   logic              reg_write;
   logic              stall;
   logic              flush;
   logic [REG_W-1:0]  rs1_num;
   logic [REG_W-1:0]  rs2_num;
   logic              wb_valid;
   logic [REG_W-1:0]  wb_reg_num;
   logic [DATA_W-1:0] wb_data;
   logic              wb_we;
   logic              fwd1_hit;
   logic              fwd2_hit;
   logic [DATA_W-1:0] fwd1_data;
   logic [DATA_W-1:0] fwd2_data;
   logic [CNT_W-1:0]  retired_cnt;

   modport master (
      output in_valid, alu_result, mem_read_data, write_reg_num, mem_to_reg, reg_write,
             stall, flush, rs1_num, rs2_num,
      input  wb_valid, wb_reg_num, wb_data, wb_we, fwd1_hit, fwd2_hit,
             fwd1_data, fwd2_data, retired_cnt
   );

   modport slave (
      input  in_valid, alu_result, mem_read_data, write_reg_num, mem_to_reg, reg_write,
             stall, flush, rs1_num, rs2_num,
      output wb_valid, wb_reg_num, wb_data, wb_we, fwd1_hit, fwd2_hit,
             fwd1_data, fwd2_data, retired_cnt
   );
endinterface

// File: rtl/mem_wb_pipe_slot.sv
// Single MEM->WB slot register: clear beats hold beats load.
module mem_wb_slot
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              hold_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] alu_i,
   input  logic [DATA_W-1:0] mem_i,
   input  logic [REG_W-1:0]  rd_i,
   input  logic              mem_to_reg_i,
   input  logic              reg_write_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] alu_o,
   output logic [DATA_W-1:0] mem_o,
   output logic [REG_W-1:0]  rd_o,
   output logic              mem_to_reg_o,
   output logic              reg_write_o
);
   localparam int SLOT_W = 3 + 2*DATA_W + REG_W;

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;

   // Next slot contents: flush empties the slot, stall keeps it, else load.
   always_comb begin
      slot_d = {valid_i, alu_i, mem_i, rd_i, mem_to_reg_i, reg_write_i};
      if (clear_i)
         slot_d = '0;
      else if (hold_i)
         slot_d = slot_q;
   end

   // Slot storage with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         slot_q <= '0;
      else
         slot_q <= slot_d;
   end

   assign {valid_o, alu_o, mem_o, rd_o, mem_to_reg_o, reg_write_o} = slot_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline of DEPTH slots with stall/flush, write-back select,
// two-operand forwarding lookup over all slots and a retired counter.
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 32
) (
   input  logic   clock,
   input  logic   reset,
   mem_wb_if.slave bus
);
   logic [DEPTH-1:0]  d_valid, d_m2r, d_rw;
   logic [DATA_W-1:0] d_alu [DEPTH];
   logic [DATA_W-1:0] d_mem [DEPTH];
   logic [REG_W-1:0]  d_rd  [DEPTH];

   logic [DEPTH-1:0]  s_valid, s_m2r, s_rw;
   logic [DATA_W-1:0] s_alu [DEPTH];
   logic [DATA_W-1:0] s_mem [DEPTH];
   logic [DATA_W-1:0] s_sel [DEPTH];
   logic [REG_W-1:0]  s_rd  [DEPTH];

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              leave;

   // Flush wins over stall, so under a flush the oldest slot still leaves
   // (and therefore commits) this cycle.
   assign leave = ~bus.stall | bus.flush;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign d_valid[gi] = bus.in_valid;
            assign d_alu[gi]   = bus.alu_result;
            assign d_mem[gi]   = bus.mem_read_data;
            assign d_rd[gi]    = bus.write_reg_num;
            assign d_m2r[gi]   = bus.mem_to_reg;
            assign d_rw[gi]    = bus.reg_write;
         end else begin : g_chain
            assign d_valid[gi] = s_valid[gi-1];
            assign d_alu[gi]   = s_alu[gi-1];
            assign d_mem[gi]   = s_mem[gi-1];
            assign d_rd[gi]    = s_rd[gi-1];
            assign d_m2r[gi]   = s_m2r[gi-1];
            assign d_rw[gi]    = s_rw[gi-1];
         end

         mem_wb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_slot (
            .clock        (clock),
            .reset        (reset),
            .clear_i      (bus.flush),
            .hold_i       (bus.stall),
            .valid_i      (d_valid[gi]),
            .alu_i        (d_alu[gi]),
            .mem_i        (d_mem[gi]),
            .rd_i         (d_rd[gi]),
            .mem_to_reg_i (d_m2r[gi]),
            .reg_write_i  (d_rw[gi]),
            .valid_o      (s_valid[gi]),
            .alu_o        (s_alu[gi]),
            .mem_o        (s_mem[gi]),
            .rd_o         (s_rd[gi]),
            .mem_to_reg_o (s_m2r[gi]),
            .reg_write_o  (s_rw[gi])
         );

         // Per-slot write-back value, shared by the WB port and forwarding.
         assign s_sel[gi] = (s_m2r[gi] == WB_SEL_ALU) ? s_alu[gi] : s_mem[gi];
      end
   endgenerate

   assign bus.wb_valid    = s_valid[DEPTH-1];
   assign bus.wb_reg_num  = s_rd[DEPTH-1];
   assign bus.wb_data     = s_sel[DEPTH-1];
   assign bus.wb_we       = s_valid[DEPTH-1] & s_rw[DEPTH-1] &
                            (s_rd[DEPTH-1] != '0) & leave;
   assign bus.retired_cnt = cnt_q;

   // Forwarding lookup: scan oldest to youngest so the youngest match wins.
   always_comb begin
      bus.fwd1_hit  = 1'b0;
      bus.fwd2_hit  = 1'b0;
      bus.fwd1_data = '0;
      bus.fwd2_data = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (s_valid[k] && s_rw[k] && (s_rd[k] != '0) && (s_rd[k] == bus.rs1_num)) begin
            bus.fwd1_hit  = 1'b1;
            bus.fwd1_data = s_sel[k];
         end
         if (s_valid[k] && s_rw[k] && (s_rd[k] != '0) && (s_rd[k] == bus.rs2_num)) begin
            bus.fwd2_hit  = 1'b1;
            bus.fwd2_data = s_sel[k];
         end
      end
   end

   // Retired count advances whenever a valid oldest slot leaves the pipe.
   always_comb begin
      cnt_d = cnt_q;
      if (s_valid[DEPTH-1] && leave)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Retired counter register with asynchronous reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (DEPTH=3, 4-bit retired counter).
module tb_mem_wb_pipe;
   import mem_wb_pipe_pkg::*;

   localparam int DW    = 32;
   localparam int RW    = 5;
   localparam int DEPTH = 3;
   localparam int CW    = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_wb_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) bus ();

   mem_wb_pipe #(.DATA_W(DW), .REG_W(RW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [RW-1:0] rd;
      logic [DW-1:0] data;
      logic          we;
   } wb_exp_t;

   typedef struct {
      logic          valid;
      logic          we;
      logic          f1h;
      logic          f2h;
      logic [DW-1:0] f1d;
      logic [DW-1:0] f2d;
      logic [CW-1:0] cnt;
   } cyc_exp_t;

   wb_exp_t  wb_q[$];
   cyc_exp_t cyc_q[$];

   // Reference: list of in-flight instructions, index 0 youngest.
   slot_t model [DEPTH];
   int    retired = 0;
   int    errors  = 0;
   int    checks  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] wb_value(input slot_t s);
      return (s.mem_to_reg == WB_SEL_MEM) ? s.mem : s.alu;
   endfunction

   // Youngest in-flight writer of rs, as {hit, data}.
   function automatic logic [DW:0] lookup(input logic [RW-1:0] rs);
      for (int k = 0; k < DEPTH; k++)
         if (model[k].valid && model[k].reg_write && model[k].rd != 0 && model[k].rd == rs)
            return {1'b1, wb_value(model[k])};
      return '0;
   endfunction

   // One clock cycle: drive inputs at negedge, queue the expected outputs,
   // then advance the reference at the posedge.
   task automatic step(input logic rst_low, input logic v, input logic [DW-1:0] alu,
                       input logic [DW-1:0] mem, input logic [RW-1:0] rd, input logic m2r,
                       input logic rw, input logic stall, input logic flush,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
      cyc_exp_t c;
      wb_exp_t  w;
      slot_t    last;
      logic     leaving;
      logic [DW:0] f1, f2;
      @(negedge clk);
      rst_n             = ~rst_low;
      bus.in_valid      = v;
      bus.alu_result    = alu;
      bus.mem_read_data = mem;
      bus.write_reg_num = rd;
      bus.mem_to_reg    = m2r;
      bus.reg_write     = rw;
      bus.stall         = stall;
      bus.flush         = flush;
      bus.rs1_num       = rs1;
      bus.rs2_num       = rs2;
      if (rst_low) begin
         for (int k = 0; k < DEPTH; k++) model[k] = SLOT_RST;
         retired = 0;
      end
      last    = model[DEPTH-1];
      leaving = !stall || flush;
      f1      = lookup(rs1);
      f2      = lookup(rs2);
      c.valid = last.valid;
      c.we    = last.valid && last.reg_write && last.rd != 0 && leaving;
      c.f1h   = f1[DW];
      c.f1d   = f1[DW-1:0];
      c.f2h   = f2[DW];
      c.f2d   = f2[DW-1:0];
      c.cnt   = CW'(retired);
      cyc_q.push_back(c);
      if (last.valid) begin
         w.rd   = last.rd;
         w.data = wb_value(last);
         w.we   = c.we;
         wb_q.push_back(w);
      end
      @(posedge clk);
      if (!rst_low) begin
         if (last.valid && leaving) retired++;
         if (flush) begin
            for (int k = 0; k < DEPTH; k++) model[k] = SLOT_RST;
         end else if (!stall) begin
            for (int k = DEPTH-1; k > 0; k--) model[k] = model[k-1];
            model[0] = '{valid: v, alu: alu, mem: mem, rd: rd, mem_to_reg: m2r, reg_write: rw};
         end
      end
   endtask

   task automatic issue(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic [RW-1:0] rd, input logic m2r, input logic rw,
                        input logic stall, input logic flush,
                        input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
      step(1'b0, v, alu, mem, rd, m2r, rw, stall, flush, rs1, rs2);
   endtask

   task automatic bubbles(input int n, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
      for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, rs1, rs2);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: per-cycle outputs every cycle, WB record whenever wb_valid.
   initial begin
      cyc_exp_t c;
      wb_exp_t  w;
      forever begin
         @(negedge clk);
         #2;
         if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("wb_valid",    64'(bus.wb_valid),    64'(c.valid));
            chk("wb_we",       64'(bus.wb_we),       64'(c.we));
            chk("fwd1_hit",    64'(bus.fwd1_hit),    64'(c.f1h));
            chk("fwd1_data",   64'(bus.fwd1_data),   64'(c.f1d));
            chk("fwd2_hit",    64'(bus.fwd2_hit),    64'(c.f2h));
            chk("fwd2_data",   64'(bus.fwd2_data),   64'(c.f2d));
            chk("retired_cnt", 64'(bus.retired_cnt), 64'(c.cnt));
         end
         if (bus.wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d expected no writeback at %0t",
                        bus.wb_reg_num, $time);
            end else begin
               w = wb_q.pop_front();
               chk("wb_reg_num", 64'(bus.wb_reg_num), 64'(w.rd));
               chk("wb_data",    64'(bus.wb_data),    64'(w.data));
               $display("wb rd=%0d data=%0h we=%0b cnt=%0d", bus.wb_reg_num, bus.wb_data,
                        bus.wb_we, bus.retired_cnt);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected run end");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < DEPTH; k++) model[k] = SLOT_RST;
      do_reset(2);

      // Latency and write-back select, memory then ALU source.
      issue(1, 32'h11, 32'hAA, 5, 1, 1, 0, 0, 5, 0);
      bubbles(3, 5, 0);
      issue(1, 32'h11, 32'hAA, 5, 0, 1, 0, 0, 5, 0);
      bubbles(3, 5, 0);

      // Stall with rd=7 sitting in the oldest slot.
      issue(1, 32'h77, 32'h70, 7, 0, 1, 0, 0, 7, 7);
      bubbles(2, 7, 7);
      for (int i = 0; i < 3; i++) issue(0, 0, 0, 0, 0, 0, 1, 0, 7, 7);
      bubbles(3, 7, 7);

      // Stall and flush together with two valid slots.
      issue(1, 32'h1, 32'h2, 3, 0, 1, 0, 0, 3, 9);
      issue(1, 32'h5, 32'h6, 9, 1, 1, 0, 0, 3, 9);
      bubbles(1, 3, 9);
      issue(0, 0, 0, 0, 0, 0, 1, 1, 3, 9);
      bubbles(2, 3, 9);

      // Forwarding priority: two writers of x4, plus an rd=0 writer.
      issue(1, 32'h10, 32'h0, 4, 0, 1, 0, 0, 4, 0);
      issue(1, 32'h20, 32'h0, 4, 0, 1, 0, 0, 4, 0);
      issue(1, 32'h30, 32'h0, 0, 0, 1, 0, 0, 4, 0);
      bubbles(3, 4, 0);

      // Reset pulse with three writes in flight.
      issue(1, 32'hA1, 32'hB1, 1, 0, 1, 0, 0, 1, 2);
      issue(1, 32'hA2, 32'hB2, 2, 1, 1, 0, 0, 1, 2);
      issue(1, 32'hA3, 32'hB3, 3, 0, 1, 0, 0, 1, 3);
      do_reset(1);
      bubbles(2, 1, 3);

      // Counter wrap: 17 retirements, including rd=0 and non-writing ones.
      do_reset(1);
      for (int i = 0; i < 17; i++)
         issue(1, 32'(i), 32'(i + 100), RW'(i % 3), 1'(i % 2), 1'(i != 5), 0, 0, 1, 2);
      bubbles(3, 1, 2);

      // Randomised traffic with occasional stall, flush and reset.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(99) == 0)
            do_reset(1);
         else
            issue($urandom_range(99) < 70, $urandom, $urandom, RW'($urandom_range(7)),
                  1'($urandom_range(1)), $urandom_range(99) < 80,
                  $urandom_range(99) < 15, $urandom_range(99) < 5,
                  RW'($urandom_range(7)), RW'($urandom_range(7)));
      end
      bubbles(4, 0, 0);

      #3;
      chk("wb_q_drained", 64'(wb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
